// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake bundle between the execute-stage control unit and muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, A, B,
        input  busy, done, result
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign handling on magnitudes and a fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e            state, state_nx;
    op_e               op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   result_q;

    logic              a_signed, b_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_q, neg_r;
    logic              special;
    logic [XLEN-1:0]   special_result;
    logic [XLEN:0]     shifted;
    logic              fits;
    logic [XLEN-1:0]   rem_sub;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic [XLEN-1:0]   fix_result;

    // Operand interpretation; a_q/b_q hold for the whole operation, so these stay stable.
    always_comb begin
        a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        mag_a    = (a_signed && a_q[XLEN-1]) ? -a_q : a_q;
        mag_b    = (b_signed && b_q[XLEN-1]) ? -b_q : b_q;
        neg_q    = (a_signed && a_q[XLEN-1]) ^ (b_signed && b_q[XLEN-1]);
        neg_r    = (op_q == OP_REM) && a_q[XLEN-1];

        special        = 1'b0;
        special_result = '0;
        if (op_q[2] && (b_q == '0)) begin
            special        = 1'b1;
            special_result = op_q[1] ? a_q : '1;
        end else if (((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_NEG) && (b_q == '1)) begin
            special        = 1'b1;
            special_result = op_q[1] ? '0 : MIN_NEG;
        end
    end

    // The 33-bit partial remainder only exists as the shifted trial value; what is kept is always < divisor.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        fits    = shifted >= {1'b0, mag_b};
        rem_sub = shifted[XLEN-1:0] - mag_b;
        sum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);

        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -quo : quo;
        rem_s  = neg_r ? -rem : rem;

        case (op_q)
            OP_MUL:                        fix_result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = quo_s;
            default:                       fix_result = rem_s;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: outputs and next state get defaults first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = PREP;
                end
            end
            PREP: begin
                bus.busy = !special;
                state_nx = special ? DONE : CALC;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (count == CNT_LAST) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            count    <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= op_e'(bus.op);
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        count <= '0;
                    end
                end
                PREP: begin
                    count <= '0;
                    prod  <= {{XLEN{1'b0}}, mag_b};
                    rem   <= '0;
                    quo   <= mag_a;
                    if (special) begin
                        result_q <= special_result;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (op_q[2]) begin
                        quo <= {quo[XLEN-2:0], fits};
                        rem <= fits ? rem_sub : shifted[XLEN-1:0];
                    end else begin
                        prod <= {sum, prod[XLEN-1:1]};
                    end
                end
                FIX: begin
                    result_q <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a 64-bit arithmetic model
// with a cycle-level protocol model compared on every falling edge.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) || (((o == 3'd4) || (o == 3'd6)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Protocol model: cycles remaining until done, counted from the accepting edge.
    bit          m_valid = 1'b0;
    logic        m_busy, m_done;
    logic [31:0] m_result, m_exp;
    int          m_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  <= 1'b1;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= 32'h0;
            m_left   <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done   <= 1'b1;
                m_busy   <= 1'b0;
                m_result <= m_exp;
            end
        end else if (bus.start) begin
            m_exp  <= ref_result(bus.op, bus.A, bus.B);
            m_left <= is_fast(bus.op, bus.A, bus.B) ? 1 : 34;
            m_busy <= !is_fast(bus.op, bus.A, bus.B);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc busy", 32'(bus.busy), 32'(m_busy));
            check("cyc done", 32'(bus.done), 32'(m_done));
            check("cyc result", bus.result, m_result);
        end
    end

    task automatic wait_model_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            idle = (m_left == 0) && !m_done;
        end
        if (!idle) check("idle wait", 32'(idle), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int  lat;
        bit  seen = 1'b0;
        int  exp_lat = is_fast(o, a, b) ? 1 : 34;
        wait_model_idle();
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        check({name, " busy after accept"}, 32'(bus.busy), 32'(exp_lat != 1));
        lat = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " latency"}, 32'(lat), 32'(exp_lat));
            check({name, " result"}, bus.result, exp);
            check({name, " busy at done"}, 32'(bus.busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] corners[5];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int first_at, second_at;
        logic [31:0] first_res, second_res;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{3'd0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[7]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC};
        vecs[8]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        corners  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = 32'h0;
        bus.B     = 32'h0;

        for (int i = 0; i < 13; i++) begin
            check($sformatf("model pin%0d", i), ref_result(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("dir%0d", i));
        end

        // Reset in the middle of a MUL discards it; result was nonzero beforehand.
        wait_model_idle();
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.A     = 32'd7;
        bus.B     = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd7, 32'd6, 32'd42, "post reset mul");

        // Start held high across two operations; operands change while busy.
        wait_model_idle();
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.A     = 32'd7;
        bus.B     = 32'd6;
        dones = 0;
        first_at = -1;
        second_at = -1;
        first_res = 32'h0;
        second_res = 32'h0;
        for (int i = 0; i < 72; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    first_at  = i;
                    first_res = bus.result;
                end else begin
                    second_at  = i;
                    second_res = bus.result;
                end
            end
            if (i == 5) begin
                bus.A = 32'd100;
                bus.B = 32'd3;
            end
            if (i == 40) begin
                bus.A = 32'd9;
                bus.B = 32'd9;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", 32'(dones), 32'd2);
        check("b2b first edge", 32'(first_at), 32'd34);
        check("b2b first result", first_res, 32'd42);
        check("b2b second edge", 32'(second_at), 32'd70);
        check("b2b second result", second_res, 32'd300);

        for (int n = 0; n < 1000; n++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 1) == 1) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 1) == 1) ? corners[$urandom_range(0, 4)] : $urandom;
            run_op(o, a, b, ref_result(o, a, b), $sformatf("rnd%0d op%0d", n, o));
        end

        wait_model_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
